// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO window (tohost, cycle counter, console FIFO).
// Define DMEM_CONSOLE_EN to build the console FIFO; otherwise console writes are ignored.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          CON_DEPTH   = 8,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        done,
   output logic [31:0] tohost,
   output logic        con_valid,
   output logic [7:0]  con_data,
   input  logic        con_ready,
   output logic        con_overflow
);
   localparam int RW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   logic          is_mmio;
   logic [1:0]    off;
   logic [RW-1:0] widx;
   logic          wr_en;
   logic          done_reg;
   logic [31:0]   tohost_reg;
   logic [31:0]   cycle_reg;
   logic [1:0]    con_status;   // {full, empty}
   logic          unused_addr;

   assign is_mmio     = (ALUResultM[31:4] == MMIO_BASE[31:4]);
   assign off         = ALUResultM[3:2];
   assign widx        = ALUResultM[RW+1:2];
   assign wr_en       = MemWriteM && reset;
   assign unused_addr = ^ALUResultM[1:0];

   always_ff @(posedge clk) begin
      if (wr_en && !is_mmio)
         mem[widx] <= WriteDataM;
   end

   // tohost captures only the first write after reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         done_reg   <= 1'b0;
         tohost_reg <= 32'd0;
      end else if (wr_en && is_mmio && off == 2'd0 && !done_reg) begin
         done_reg   <= 1'b1;
         tohost_reg <= WriteDataM;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         cycle_reg <= 32'd0;
      else
         cycle_reg <= cycle_reg + 32'd1;
   end

   assign done   = done_reg;
   assign tohost = tohost_reg;

`ifdef DMEM_CONSOLE_EN
   localparam int AW = $clog2(CON_DEPTH);

   logic [7:0]  fifo [CON_DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        ovf_reg;
   logic        empty;
   logic        full;
   logic        push_req;
   logic        push;
   logic        pop;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop      = !empty && con_ready;
   assign push_req = wr_en && is_mmio && off == 2'd1;
   // a same-cycle pop frees the slot, so a push into a full FIFO is still accepted
   assign push     = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (push)
         fifo[wr_ptr_reg[AW-1:0]] <= WriteDataM[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_req && !push)
            ovf_reg <= 1'b1;
      end
   end

   assign con_valid    = !empty;
   assign con_data     = fifo[rd_ptr_reg[AW-1:0]];
   assign con_overflow = ovf_reg;
   assign con_status   = {full, empty};
`else
   logic unused_console;

   assign unused_console = con_ready;
   assign con_valid      = 1'b0;
   assign con_data       = 8'd0;
   assign con_overflow   = 1'b0;
   assign con_status     = 2'b01;
`endif

   always_comb begin
      ReadDataM = 32'd0;
      if (is_mmio) begin
         case (off)
            2'd0:    ReadDataM = tohost_reg;
            2'd1:    ReadDataM = {30'd0, con_status};
            2'd2:    ReadDataM = cycle_reg;
            default: ReadDataM = 32'd0;
         endcase
      end else begin
         ReadDataM = mem[widx];
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expectations, a negedge monitor checks them.
// Console expectations follow whether DMEM_CONSOLE_EN is defined for this build.
module tb_dmem_responder;
   localparam logic [31:0] A_TOHOST = 32'hFFFF_FFF0;
   localparam logic [31:0] A_CON    = 32'hFFFF_FFF4;
   localparam logic [31:0] A_CYC    = 32'hFFFF_FFF8;
   localparam logic [31:0] A_RSV    = 32'hFFFF_FFFC;

   localparam int S_RD = 0, S_DONE = 1, S_TOHOST = 2, S_VALID = 3,
                  S_DATA = 4, S_OVF = 5, S_CONQ = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [31:0] ALUResultM = 32'd0;
   logic [31:0] WriteDataM = 32'd0;
   logic [31:0] ReadDataM;
   logic        done;
   logic [31:0] tohost;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        con_ready = 1'b0;
   logic        con_overflow;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t        sb[$];
   logic [7:0]  con_q[$];
   chk_t        mon_e;
   logic [31:0] mon_act;
   logic [7:0]  mon_b;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   dmem_responder dut (
      .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .done(done), .tohost(tohost),
      .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
      .con_overflow(con_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pick(input int sel);
      case (sel)
         S_RD:     return ReadDataM;
         S_DONE:   return {31'd0, done};
         S_TOHOST: return tohost;
         S_VALID:  return {31'd0, con_valid};
         S_DATA:   return {24'd0, con_data};
         S_OVF:    return {31'd0, con_overflow};
         default:  return 32'(con_q.size());
      endcase
   endfunction

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e   = sb.pop_front();
         mon_act = pick(mon_e.sel);
         total++;
         if (mon_act !== mon_e.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", mon_e.name, mon_act, mon_e.exp);
         end else
            $display("ok   %s: %h", mon_e.name, mon_act);
      end
      if (con_valid === 1'b1 && con_ready) begin
         total++;
         if (con_q.size() == 0) begin
            bad++;
            $display("FAIL con_pop: got %h want no byte", con_data);
         end else begin
            mon_b = con_q.pop_front();
            if (con_data !== mon_b) begin
               bad++;
               $display("FAIL con_pop: got %h want %h", con_data, mon_b);
            end else
               $display("ok   con_pop: %h", con_data);
         end
      end
   end

   task automatic step(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
      @(posedge clk);
      #1;
      reset      = rst;
      MemWriteM  = we;
      ALUResultM = a;
      WriteDataM = d;
      con_ready  = rdy;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
      step(1'b1, 1'b1, a, d, rdy);
   endtask

   task automatic rd(input logic [31:0] a, input logic rdy);
      step(1'b1, 1'b0, a, 32'd0, rdy);
   endtask

   task automatic expect_now(input int sel, input logic [31:0] exp, input string name);
      sb.push_back('{cyc, sel, exp, name});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      step(1'b0, 1'b0, A_CYC, 32'd0, 1'b0);
      step(1'b0, 1'b0, A_CYC, 32'd0, 1'b0);
      expect_now(S_RD, 32'd0, "rst_cycle");
      expect_now(S_DONE, 32'd0, "rst_done");
      expect_now(S_TOHOST, 32'd0, "rst_tohost");
      expect_now(S_VALID, 32'd0, "rst_con_valid");
      expect_now(S_OVF, 32'd0, "rst_overflow");

      // cycle counter: 100 cycles out of reset, then forced wrap
      step(1'b1, 1'b0, A_CYC, 32'd0, 1'b0);
      for (int i = 0; i < 100; i++) rd(A_CYC, 1'b0);
      expect_now(S_RD, 32'd100, "cycle_100");
      rd(A_CYC, 1'b0);
      force dut.cycle_reg = 32'hFFFF_FFFF;
      expect_now(S_RD, 32'hFFFF_FFFF, "cycle_forced");
      @(negedge clk);
      #1;
      release dut.cycle_reg;
      rd(A_CYC, 1'b0);
      expect_now(S_RD, 32'd0, "cycle_wrap");

      // RAM
      wr(32'h40, 32'h1111_1111, 1'b0);
      wr(32'h40, 32'hDEAD_BEEF, 1'b0);
      expect_now(S_RD, 32'h1111_1111, "ram_same_cycle_old");
      wr(32'h44, 32'hCAFE_F00D, 1'b0);
      rd(32'h40, 1'b0);
      expect_now(S_RD, 32'hDEAD_BEEF, "ram_read");
      rd(32'h40 + 32'd256, 1'b0);
      expect_now(S_RD, 32'hDEAD_BEEF, "ram_alias");
      rd(32'h44, 1'b0);
      expect_now(S_RD, 32'hCAFE_F00D, "ram_next_word");

      // tohost
      wr(A_TOHOST, 32'd25, 1'b0);
      expect_now(S_DONE, 32'd0, "done_not_yet");
      rd(A_TOHOST, 1'b0);
      expect_now(S_DONE, 32'd1, "done_set");
      expect_now(S_TOHOST, 32'd25, "tohost_25");
      expect_now(S_RD, 32'd25, "tohost_read");
      wr(A_TOHOST, 32'd7, 1'b0);
      wr(A_CYC, 32'h5555_5555, 1'b0);
      rd(A_TOHOST, 1'b0);
      expect_now(S_TOHOST, 32'd25, "tohost_sticky");
      rd(A_RSV, 1'b0);
      expect_now(S_RD, 32'd0, "reserved_read");
      step(1'b0, 1'b1, A_TOHOST, 32'd99, 1'b0);
      step(1'b0, 1'b1, 32'h40, 32'h0000_0BAD, 1'b0);
      rd(A_TOHOST, 1'b0);
      expect_now(S_DONE, 32'd0, "done_after_rst");
      expect_now(S_TOHOST, 32'd0, "tohost_after_rst");
      rd(32'h40, 1'b0);
      expect_now(S_RD, 32'hDEAD_BEEF, "ram_write_in_rst");

`ifdef DMEM_CONSOLE_EN
      // console ordering
      wr(A_CON, 32'h41, 1'b0); con_q.push_back(8'h41);
      expect_now(S_VALID, 32'd0, "con_valid_latency");
      wr(A_CON, 32'h42, 1'b0); con_q.push_back(8'h42);
      wr(A_CON, 32'h43, 1'b0); con_q.push_back(8'h43);
      rd(A_CON, 1'b0);
      expect_now(S_VALID, 32'd1, "con_valid_up");
      expect_now(S_DATA, 32'h41, "con_head");
      expect_now(S_RD, 32'd0, "con_status_mid");
      for (int i = 0; i < 3; i++) rd(A_CON, 1'b1);
      rd(A_CON, 1'b0);
      expect_now(S_VALID, 32'd0, "con_drained");
      expect_now(S_RD, 32'd1, "con_status_empty");
      expect_now(S_CONQ, 32'd0, "con_all_popped");

      // overflow
      for (int i = 0; i < 8; i++) begin
         wr(A_CON, 32'h30 + 32'(i), 1'b0);
         con_q.push_back(8'(8'h30 + i));
      end
      rd(A_CON, 1'b0);
      expect_now(S_RD, 32'd2, "con_status_full");
      expect_now(S_OVF, 32'd0, "ovf_clear");
      wr(A_CON, 32'h39, 1'b0);
      rd(A_CON, 1'b0);
      expect_now(S_OVF, 32'd1, "ovf_set");
      expect_now(S_RD, 32'd2, "full_after_drop");
      wr(A_CON, 32'h3A, 1'b1); con_q.push_back(8'h3A);
      rd(A_CON, 1'b0);
      expect_now(S_RD, 32'd2, "full_push_pop");
      expect_now(S_DATA, 32'h31, "head_after_push_pop");
      for (int i = 0; i < 8; i++) rd(A_CON, 1'b1);
      rd(A_CON, 1'b0);
      expect_now(S_RD, 32'd1, "empty_after_drain");
      expect_now(S_CONQ, 32'd0, "ovf_all_popped");

      // reset mid-drain
      wr(A_CON, 32'h61, 1'b0);
      wr(A_CON, 32'h62, 1'b0);
      step(1'b0, 1'b0, A_CON, 32'd0, 1'b0);
      con_q.delete();
      rd(A_CON, 1'b1);
      expect_now(S_VALID, 32'd0, "rst_discard");
      expect_now(S_OVF, 32'd0, "rst_ovf_clear");
      expect_now(S_RD, 32'd1, "rst_status_empty");
`else
      for (int i = 0; i < 9; i++) wr(A_CON, 32'h41 + 32'(i), 1'b0);
      rd(A_CON, 1'b0);
      expect_now(S_VALID, 32'd0, "nocon_valid");
      expect_now(S_DATA, 32'd0, "nocon_data");
      expect_now(S_OVF, 32'd0, "nocon_ovf");
      expect_now(S_RD, 32'd1, "nocon_status");
      rd(A_CON, 1'b1);
      expect_now(S_VALID, 32'd0, "nocon_valid_ready");
`endif

      rd(32'h0, 1'b0);
      rd(32'h0, 1'b0);
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
